// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the program-image writer and the core's decoder.
package instr_encoder_pkg;

  // Symbolic instruction kinds presented on in_kind
  localparam logic [2:0] KIND_ADD = 3'd0;
  localparam logic [2:0] KIND_SUB = 3'd1;
  localparam logic [2:0] KIND_AND = 3'd2;
  localparam logic [2:0] KIND_OR  = 3'd3;
  localparam logic [2:0] KIND_SLT = 3'd4;
  localparam logic [2:0] KIND_LW  = 3'd5;
  localparam logic [2:0] KIND_SW  = 3'd6;
  localparam logic [2:0] KIND_BEQ = 3'd7;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type function codes
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  // Loader FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational kind/fields -> 32-bit MIPS instruction word.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o
);

  // Select R-type func or I-type opcode and assemble the word
  always_comb begin
    word_o = '0;
    case (kind_i)
      KIND_ADD: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNC_ADD};
      KIND_SUB: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNC_SUB};
      KIND_AND: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNC_AND};
      KIND_OR:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNC_OR};
      KIND_SLT: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FUNC_SLT};
      KIND_LW:  word_o = {OP_LW,  rs_i, rt_i, imm_i};
      KIND_SW:  word_o = {OP_SW,  rs_i, rt_i, imm_i};
      KIND_BEQ: word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      default:  word_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-image writer: accepts symbolic instructions and writes encoded
// words sequentially into instruction memory starting at address 0.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          done
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   packed_word;
  logic          hs;

  instr_pack u_pack (
    .kind_i (in_kind),
    .rs_i   (in_rs),
    .rt_i   (in_rt),
    .rd_i   (in_rd),
    .imm_i  (in_imm),
    .word_o (packed_word)
  );

  // Ready and done depend on the state register alone
  assign in_ready  = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign hs        = in_valid & in_ready;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;

  // Next-state: start (re)opens a load; each handshake stages one write
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = packed_word;
          ptr_d       = ptr_q + PTR_ONE;
          count_d     = count_q + CNT_ONE;
          // Last slot filled terminates the load so the address never wraps
          if (in_last || (ptr_q == '1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 64-word instance and a 4-word
// instance share the instruction inputs but have separate start pulses.
module tb_instr_encoder;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start6, start2;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        in_last;

  logic        in_ready6, mem_we6, done6;
  logic [5:0]  mem_addr6;
  logic [31:0] mem_wdata6;
  logic [6:0]  count6;

  logic        in_ready2, mem_we2, done2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  exp_t q6[$];
  exp_t q2[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_encoder #(.AW(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .in_valid(in_valid),
    .in_ready(in_ready6), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we6),
    .mem_addr(mem_addr6), .mem_wdata(mem_wdata6), .count(count6), .done(done6)
  );

  instr_encoder #(.AW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid),
    .in_ready(in_ready2), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .count(count2), .done(done2)
  );

  // Write monitors: every write strobe must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && mem_we6) begin
      vectors++;
      if (q6.size() == 0) begin
        miscompares++;
        $display("FAIL wr64_unexpected: addr=%0d wdata=%08h, required no write", mem_addr6, mem_wdata6);
      end else begin
        exp_t e;
        e = q6.pop_front();
        if (mem_addr6 !== e.addr || mem_wdata6 !== e.word) begin
          miscompares++;
          $display("FAIL wr64: addr=%0d wdata=%08h, required addr=%0d wdata=%08h",
                   mem_addr6, mem_wdata6, e.addr, e.word);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_we2) begin
      vectors++;
      if (q2.size() == 0) begin
        miscompares++;
        $display("FAIL wr4_unexpected: addr=%0d wdata=%08h, required no write", mem_addr2, mem_wdata2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        if ({4'b0, mem_addr2} !== e.addr || mem_wdata2 !== e.word) begin
          miscompares++;
          $display("FAIL wr4: addr=%0d wdata=%08h, required addr=%0d wdata=%08h",
                   mem_addr2, mem_wdata2, e.addr, e.word);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to the 64-word instance and wait for its handshake
  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic last,
                      input logic [5:0] eaddr, input logic [31:0] eword);
    exp_t e;
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready6) begin
        e.addr = eaddr;
        e.word = eword;
        q6.push_back(e);
        tick();
        return;
      end
      tick();
    end
    vectors++;
    miscompares++;
    $display("FAIL handshake_timeout: in_ready=0 for 20 cycles, required 1");
  endtask

  task automatic pulse_start6();
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ptr;
    exp_t e;
    rst_n = 1'b0; start6 = 1'b0; start2 = 1'b0; in_valid = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
    #1;
    chk("rst_mem_we", {31'b0, mem_we6}, 32'd0);
    chk("rst_mem_addr", {26'b0, mem_addr6}, 32'd0);
    chk("rst_mem_wdata", mem_wdata6, 32'd0);
    chk("rst_count", {25'b0, count6}, 32'd0);
    chk("rst_done", {31'b0, done6}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready6}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", {31'b0, in_ready6}, 32'd0);

    // Single ADD terminated by last
    pulse_start6();
    chk("load_in_ready", {31'b0, in_ready6}, 32'd1);
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, 6'd0, 32'h00221820);
    in_valid = 1'b0;
    chk("add_done", {31'b0, done6}, 32'd1);
    chk("add_count", {25'b0, count6}, 32'd1);
    chk("add_ready_low", {31'b0, in_ready6}, 32'd0);
    tick();

    // Back-to-back stream: SUB, LW, SW, BEQ (rd ignored)
    pulse_start6();
    send(3'd1, 5'd4,  5'd5, 5'd6,  16'h0000, 1'b0, 6'd0, 32'h00853022);
    send(3'd5, 5'd29, 5'd8, 5'd0,  16'h0004, 1'b0, 6'd1, 32'h8FA80004);
    send(3'd6, 5'd0,  5'd5, 5'd0,  16'h0008, 1'b0, 6'd2, 32'hAC050008);
    send(3'd7, 5'd1,  5'd2, 5'd31, 16'hFFFF, 1'b1, 6'd3, 32'h1022FFFF);
    in_valid = 1'b0;
    chk("stream_count", {25'b0, count6}, 32'd4);
    tick();

    // AND / OR / SLT, then start coinciding with the final write
    pulse_start6();
    send(3'd2, 5'd7,  5'd8,  5'd9,  16'h1234, 1'b0, 6'd0, 32'h00E84824);
    send(3'd3, 5'd10, 5'd11, 5'd12, 16'h0000, 1'b0, 6'd1, 32'h014B6025);
    send(3'd4, 5'd2,  5'd3,  5'd1,  16'h0000, 1'b1, 6'd2, 32'h0043082A);
    in_valid = 1'b0;
    chk("final_we_with_done", {31'b0, mem_we6 & done6}, 32'd1);
    pulse_start6();
    chk("restart_ready", {31'b0, in_ready6}, 32'd1);
    chk("restart_count", {25'b0, count6}, 32'd0);
    chk("restart_done", {31'b0, done6}, 32'd0);

    // Random in_valid with start pulses during LOAD: pointer keeps advancing
    ptr = 0;
    in_kind = 3'd0; in_rs = 5'd1; in_rt = 5'd2; in_imm = '0; in_last = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_rd = 5'(i);
      in_valid = 1'($urandom_range(0, 1));
      start6 = 1'($urandom_range(0, 1));
      if (in_valid && in_ready6) begin
        e.addr = 6'(ptr);
        e.word = 32'h00220020 | (32'(i) << 11);
        q6.push_back(e);
        ptr++;
      end
      tick();
    end
    start6 = 1'b0;
    send(3'd0, 5'd1, 5'd2, 5'd31, 16'h0000, 1'b1, 6'(ptr), 32'h0022F820);
    in_valid = 1'b0;
    chk("rand_count", {25'b0, count6}, ptr + 1);
    tick();
    pulse_start6();
    send(3'd0, 5'd1, 5'd2, 5'd5, 16'h0000, 1'b1, 6'd0, 32'h00222820);
    in_valid = 1'b0;
    tick();

    // 4-word instance: six instructions without last, only four land
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    in_kind = 3'd0; in_rs = 5'd1; in_rt = 5'd2; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_rd = 5'(i);
      if (i < 4) begin
        e.addr = 6'(i);
        e.word = 32'h00220020 | (32'(i) << 11);
        q2.push_back(e);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("full_done", {31'b0, done2}, 32'd1);
    chk("full_count", {29'b0, count2}, 32'd4);
    chk("full_ready_low", {31'b0, in_ready2}, 32'd0);
    tick();

    // Reset in the cycle after a handshake discards the pending write
    pulse_start6();
    in_kind = 3'd0; in_rd = 5'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_we", {31'b0, mem_we6}, 32'd0);
    chk("rstmid_count", {25'b0, count6}, 32'd0);
    chk("rstmid_ready", {31'b0, in_ready6}, 32'd0);
    chk("rstmid_done", {31'b0, done6}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    chk("q64_drained", q6.size(), 32'd0);
    chk("q4_drained", q2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
